event_strch_gen: RTL and testbench



---
 rtl/event_strch_gen.sv | 107 ++++++++++
 tb/tb_event_strch_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/event_strch_gen.sv
// Raw-event source stage: synchronizes raw_in, detects rising edges and turns each accepted
// edge into a one-cycle event pulse followed by a programmable stretch level and hold-off.
module event_strch_gen #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned HOLDOFF_CYC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             raw_in,
  input  logic             enable,
  input  logic [CNT_W-1:0] strch_len,
  output logic             event_op,
  output logic             strch_op,
  output logic             busy,
  output logic [3:0]       ovr_cnt
);

  localparam int unsigned HoldW = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam logic [HoldW-1:0] HoldLoad = HoldW'((HOLDOFF_CYC == 0) ? 0 : HOLDOFF_CYC - 1);

  typedef enum logic [1:0] {StIdle, StEvent, StStretch, StHoldoff} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_det;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [HoldW-1:0]       hold_q, hold_d;
  logic [3:0]             ovr_q, ovr_d;
  logic                   event_q, strch_q, busy_q;

  assign edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      StIdle: begin
        if (edge_det && enable) state_d = StEvent;
      end
      StEvent: begin
        // strch_len is only looked at here; later changes do not touch a running stretch
        if (strch_len != '0) begin
          state_d = StStretch;
          cnt_d   = strch_len - CNT_W'(1);
        end else if (HOLDOFF_CYC != 0) begin
          state_d = StHoldoff;
          hold_d  = HoldLoad;
        end else begin
          state_d = StIdle;
        end
      end
      StStretch: begin
        if (cnt_q == '0) begin
          if (HOLDOFF_CYC != 0) begin
            state_d = StHoldoff;
            hold_d  = HoldLoad;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StHoldoff: begin
        if (hold_q == '0) state_d = StIdle;
        else              hold_d  = hold_q - HoldW'(1);
      end
      default: state_d = StIdle;
    endcase
    // Edges arriving outside IDLE, including on the exit cycle, are dropped and counted
    if (edge_det && (state_q != StIdle) && (ovr_q != 4'hF)) ovr_d = ovr_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      state_q <= StIdle;
      cnt_q   <= '0;
      hold_q  <= '0;
      ovr_q   <= '0;
      event_q <= 1'b0;
      strch_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_in};
      hist_q  <= sync_q[SYNC_STAGES-1];
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      ovr_q   <= ovr_d;
      event_q <= (state_d == StEvent);
      strch_q <= (state_d == StStretch);
      busy_q  <= (state_d != StIdle);
    end
  end

  assign event_op = event_q;
  assign strch_op = strch_q;
  assign busy     = busy_q;
  assign ovr_cnt  = ovr_q;

endmodule

// File: tb/tb_event_strch_gen.sv
// Bench for event_strch_gen: default instance plus a SYNC_STAGES=3, HOLDOFF_CYC=0 instance,
// each sequence checked against queued expectations of event cycle, stretch length, idle cycle.
module tb_event_strch_gen;

  typedef struct {
    int ev;
    int nst;
    int idle;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  logic       reset_a, raw_a, en_a, event_a, strch_a, busy_a;
  logic [7:0] len_a;
  logic [3:0] ovr_a;
  logic       reset_b, raw_b, en_b, event_b, strch_b, busy_b;
  logic [7:0] len_b;
  logic [3:0] ovr_b;

  exp_t q_a[$];
  exp_t q_b[$];
  bit   in_seq[2];
  int   ev_cyc[2];
  int   ev_cnt[2];
  int   st_cnt[2];

  event_strch_gen #(.SYNC_STAGES(2), .CNT_W(8), .HOLDOFF_CYC(4)) dut_a (
    .clk      (clk),
    .reset    (reset_a),
    .raw_in   (raw_a),
    .enable   (en_a),
    .strch_len(len_a),
    .event_op (event_a),
    .strch_op (strch_a),
    .busy     (busy_a),
    .ovr_cnt  (ovr_a)
  );

  event_strch_gen #(.SYNC_STAGES(3), .CNT_W(8), .HOLDOFF_CYC(0)) dut_b (
    .clk      (clk),
    .reset    (reset_b),
    .raw_in   (raw_b),
    .enable   (en_b),
    .strch_len(len_b),
    .event_op (event_b),
    .strch_op (strch_b),
    .busy     (busy_b),
    .ovr_cnt  (ovr_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int idx, input logic ev, input logic st, input logic bz);
    exp_t e;
    if (!in_seq[idx] && (bz || ev)) begin
      in_seq[idx] = 1'b1;
      ev_cyc[idx] = cyc;
      ev_cnt[idx] = 0;
      st_cnt[idx] = 0;
    end
    if (in_seq[idx]) begin
      if (ev) ev_cnt[idx]++;
      if (st) st_cnt[idx]++;
      if (!bz) begin
        in_seq[idx] = 1'b0;
        if ((idx == 0 && q_a.size() == 0) || (idx == 1 && q_b.size() == 0)) begin
          checks++;
          fails++;
          $display("FAIL unexpected_seq dut%0d: event at cycle %0d, none expected", idx, ev_cyc[idx]);
        end else begin
          e = (idx == 0) ? q_a.pop_front() : q_b.pop_front();
          check($sformatf("dut%0d_event_cycle", idx), ev_cyc[idx], e.ev);
          check($sformatf("dut%0d_event_pulses", idx), ev_cnt[idx], 1);
          check($sformatf("dut%0d_stretch_len", idx), st_cnt[idx], e.nst);
          check($sformatf("dut%0d_idle_cycle", idx), cyc, e.idle);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, event_a, strch_a, busy_a);
    mon(1, event_b, strch_b, busy_b);
  end

  // Returns at the negedge after posedge t; inputs set there are captured at posedge t+1
  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic fire(input int idx, input int p0, input logic [7:0] len, input int hold,
                      input int ev, input int nst, input int idle);
    goto(p0 - 1);
    if (idx == 0) begin
      len_a = len;
      raw_a = 1'b1;
      q_a.push_back('{ev, nst, idle});
    end else begin
      len_b = len;
      raw_b = 1'b1;
      q_b.push_back('{ev, nst, idle});
    end
    goto(p0 + hold - 1);
    if (idx == 0) raw_a = 1'b0;
    else          raw_b = 1'b0;
  endtask

  task automatic pulse(input int idx, input int p);
    goto(p - 1);
    if (idx == 0) raw_a = 1'b1;
    else          raw_b = 1'b1;
    goto(p);
    if (idx == 0) raw_a = 1'b0;
    else          raw_b = 1'b0;
  endtask

  initial begin
    reset_a = 1'b0; raw_a = 1'b0; en_a = 1'b1; len_a = 8'd0;
    reset_b = 1'b0; raw_b = 1'b0; en_b = 1'b1; len_b = 8'd0;
    @(negedge clk);
    goto(3);
    check("rst_event_op", event_a, 0);
    check("rst_strch_op", strch_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_ovr_cnt", ovr_a, 0);
    check("rst_b_busy", busy_b, 0);
    check("rst_b_ovr_cnt", ovr_b, 0);
    reset_a = 1'b1;
    reset_b = 1'b1;

    // Basic len=5, raw held high; strch_len changed mid-stretch
    goto(9);
    len_a = 8'd5;
    raw_a = 1'b1;
    q_a.push_back('{12, 5, 22});
    goto(13);
    len_a = 8'd9;
    goto(29);
    raw_a = 1'b0;
    goto(35);
    check("held_high_ovr", ovr_a, 0);

    fire(0, 40, 8'd0, 1, 42, 0, 47);
    fire(0, 50, 8'd255, 1, 52, 255, 312);

    // enable low in IDLE: edge ignored, not counted
    goto(319);
    en_a = 1'b0;
    pulse(0, 322);
    goto(330);
    check("disabled_ovr", ovr_a, 0);
    check("disabled_busy", busy_a, 0);
    en_a = 1'b1;

    // enable dropped mid-stretch
    fire(0, 340, 8'd8, 1, 342, 8, 355);
    goto(344);
    en_a = 1'b0;
    goto(359);
    en_a = 1'b1;

    // Re-triggers during STRETCH/HOLDOFF; round 2 ends with an edge on the HOLDOFF exit cycle
    fire(0, 370, 8'd10, 1, 372, 10, 387);
    for (int k = 0; k < 7; k++) pulse(0, 372 + 2 * k);
    goto(390);
    check("ovr_after_7", ovr_a, 7);
    fire(0, 400, 8'd10, 1, 402, 10, 417);
    for (int k = 0; k < 7; k++) pulse(0, 403 + 2 * k);
    goto(420);
    check("ovr_after_14", ovr_a, 14);
    fire(0, 440, 8'd10, 1, 442, 10, 457);
    for (int k = 0; k < 7; k++) pulse(0, 442 + 2 * k);
    goto(460);
    check("ovr_saturated", ovr_a, 15);

    // Reset at STRETCH count 3: seven stretch cycles seen, then everything clear
    fire(0, 470, 8'd10, 1, 472, 7, 480);
    goto(479);
    reset_a = 1'b0;
    goto(480);
    check("midrst_event_op", event_a, 0);
    check("midrst_strch_op", strch_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_ovr_cnt", ovr_a, 0);
    reset_a = 1'b1;
    fire(0, 490, 8'd3, 1, 492, 3, 500);

    // SYNC_STAGES=3, HOLDOFF_CYC=0: edge on first IDLE cycle accepted
    fire(1, 520, 8'd4, 1, 523, 4, 528);
    q_b.push_back('{529, 4, 534});
    pulse(1, 526);
    // Edge on the last STRETCH cycle rejected
    fire(1, 540, 8'd4, 1, 543, 4, 548);
    pulse(1, 545);
    goto(555);
    check("b_last_stretch_ovr", ovr_b, 1);
    check("b_idle_busy", busy_b, 0);

    goto(565);
    check("pending_a", q_a.size(), 0);
    check("pending_b", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
